spectrum_bank_ctrl: RTL and testbench



---
 rtl/spectrum_pkg.sv | 15 +
 rtl/spectrum_bank_ctrl_vs_edge_det.sv | 23 ++
 rtl/spectrum_bank_ctrl.sv | 140 ++++++++++++++
 tb/tb_spectrum_bank_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants and FSM encoding for the spectrum ping-pong bank controller.
package spectrum_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_FULL = 2'd2
    } wstate_e;

    localparam int unsigned FFT_POINT_DEF = 256;
    localparam int unsigned ADDR_BITS_DEF = 8;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned DROP_CNT_W    = 8;

endpackage

// File: rtl/spectrum_bank_ctrl_vs_edge_det.sv
// Registers vsync and flags its rising edge. The register resets high so that a
// vsync already asserted when reset releases is not mistaken for a new frame.
module vs_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vs_i,
    output logic vs_rise_o
);

    logic vs_q;

    // Delayed copy of vsync for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vs_i;
        end
    end

    assign vs_rise_o = vs_i & ~vs_q;

endmodule

// File: rtl/spectrum_bank_ctrl.sv
// Ping-pong scheduler: fills the bank the display is not reading with one FFT
// frame, then hands it over to the display only on a vsync rising edge.
module spectrum_bank_ctrl
    import spectrum_pkg::*;
#(
    parameter int unsigned FFT_POINT = FFT_POINT_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                  pix_clk_i,
    input  logic                  rst_i,
    input  logic                  vs_in_i,
    input  logic                  fft_valid_i,
    input  logic                  fft_last_i,
    input  logic [DATA_W-1:0]     fft_data_i,
    output logic                  fft_ready_o,
    output logic                  wr_en_o,
    output logic                  wr_bank_o,
    output logic [ADDR_BITS-1:0]  wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic                  rd_bank_o,
    output logic                  frame_swap_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(FFT_POINT - 1);

    wstate_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    ready_q, ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic                    swap_q, swap_d;
    logic                    vs_rise;
    logic                    accept;

    vs_edge_det u_vs_edge_det (
        .clk_i     (pix_clk_i),
        .rst_i     (rst_i),
        .vs_i      (vs_in_i),
        .vs_rise_o (vs_rise)
    );

    assign accept = fft_valid_i & ready_q;

    // State register plus registered outputs.
    always_ff @(posedge pix_clk_i) begin
        if (rst_i) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            rd_bank_q <= 1'b0;
            drop_q    <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            swap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_bank_q <= rd_bank_d;
            drop_q    <= drop_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            swap_q    <= swap_d;
        end
    end

    // Next-state: frame fill, drop of short frames, swap at vsync when full.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_bank_d = rd_bank_q;
        drop_d    = drop_q;
        case (state_q)
            W_IDLE: begin
                if (accept) begin
                    if (FFT_POINT == 1) begin
                        state_d = W_FULL;
                    end else if (fft_last_i) begin
                        drop_d = (drop_q == '1) ? drop_q : drop_q + 1'b1;
                    end else begin
                        state_d = W_FILL;
                        addr_d  = ADDR_BITS'(1);
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    if (addr_q == LastAddr) begin
                        // Completion wins over fft_last; the frame is full either way.
                        state_d = W_FULL;
                        addr_d  = '0;
                    end else if (fft_last_i) begin
                        state_d = W_IDLE;
                        addr_d  = '0;
                        drop_d  = (drop_q == '1) ? drop_q : drop_q + 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            W_FULL: begin
                if (vs_rise) begin
                    state_d   = W_IDLE;
                    addr_d    = '0;
                    rd_bank_d = ~rd_bank_q;
                end
            end
            default: begin
                state_d = W_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Output decode: ready follows the upcoming state so back-pressure is immediate.
    always_comb begin
        ready_d   = (state_d != W_FULL);
        wr_en_d   = accept;
        wr_addr_d = accept ? addr_q : wr_addr_q;
        wr_data_d = accept ? fft_data_i : wr_data_q;
        swap_d    = (state_q == W_FULL) && vs_rise;
    end

    assign fft_ready_o  = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_bank_o    = ~rd_bank_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign rd_bank_o    = rd_bank_q;
    assign frame_swap_o = swap_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// Self-checking bench for spectrum_bank_ctrl: a frame-level model predicts every
// output each cycle, and literal checks pin key points of each scenario.
module tb_spectrum_bank_ctrl;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_in;
    logic        fft_valid;
    logic        fft_last;
    logic [31:0] fft_data;
    logic        fft_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_bank;
    logic        frame_swap;
    logic [7:0]  drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    spectrum_bank_ctrl dut (
        .pix_clk_i    (clk),
        .rst_i        (rst),
        .vs_in_i      (vs_in),
        .fft_valid_i  (fft_valid),
        .fft_last_i   (fft_last),
        .fft_data_i   (fft_data),
        .fft_ready_o  (fft_ready),
        .wr_en_o      (wr_en),
        .wr_bank_o    (wr_bank),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .rd_bank_o    (rd_bank),
        .frame_swap_o (frame_swap),
        .drop_cnt_o   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Frame-level model: beats received so far, whether a full frame waits, display bank.
    int          m_count = 0;
    bit          m_full = 0;
    bit          m_rd = 0;
    int          m_drops = 0;
    bit          m_vs_prev = 1;
    bit          e_ready = 0;
    bit          e_wr_en = 0;
    int          e_wr_addr = 0;
    logic [31:0] e_wr_data = 0;
    bit          e_swap = 0;
    bit          started = 0;

    always @(posedge clk) begin
        bit rise;
        bit acc;
        started = 1;
        if (rst) begin
            m_count = 0; m_full = 0; m_rd = 0; m_drops = 0; m_vs_prev = 1;
            e_ready = 0; e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_swap = 0;
        end else begin
            rise = vs_in && !m_vs_prev;
            m_vs_prev = vs_in;
            acc = fft_valid && e_ready;
            e_wr_en = 0;
            e_swap = 0;
            if (acc) begin
                e_wr_en = 1;
                e_wr_addr = m_count;
                e_wr_data = fft_data;
                if (m_count == N - 1) begin
                    m_full = 1;
                    m_count = 0;
                end else if (fft_last) begin
                    if (m_drops < 255) m_drops++;
                    m_count = 0;
                end else begin
                    m_count++;
                end
            end else if (m_full && rise) begin
                m_rd = !m_rd;
                e_swap = 1;
                m_full = 0;
            end
            e_ready = !m_full;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            chk("fft_ready", 32'(fft_ready), 32'(e_ready));
            chk("wr_en", 32'(wr_en), 32'(e_wr_en));
            chk("wr_bank", 32'(wr_bank), 32'(!m_rd));
            chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
            chk("wr_data", wr_data, e_wr_data);
            chk("rd_bank", 32'(rd_bank), 32'(m_rd));
            chk("frame_swap", 32'(frame_swap), 32'(e_swap));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        chk(nm, act, req);
    endtask

    // Called at a negedge; waits (bounded) for ready, then presents one beat for one edge.
    task automatic send_beat(input logic [31:0] d, input bit last);
        int t = 0;
        while (!fft_ready && t < 1000) begin
            fft_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            miscompares++;
            $display("FAIL ready_timeout: got 0 required 1 at %0t", $time);
        end
        fft_valid = 1'b1;
        fft_data  = d;
        fft_last  = last;
        @(negedge clk);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int tag);
        for (int i = 0; i < n; i++) send_beat(32'(tag * 4096 + i), (i == last_at));
    endtask

    task automatic vs_pulse(input bit rd_after);
        vs_in = 1'b1;
        @(negedge clk);
        lit("swap_pulse", 32'(frame_swap), 32'(1));
        lit("swap_rd_bank", 32'(rd_bank), 32'(rd_after));
        @(negedge clk);
        lit("swap_one_cycle", 32'(frame_swap), 32'(0));
        vs_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; vs_in = 1'b0; fft_valid = 1'b0; fft_last = 1'b0; fft_data = '0;
        repeat (3) @(negedge clk);
        lit("rst_ready", 32'(fft_ready), 32'(0));
        lit("rst_wr_bank", 32'(wr_bank), 32'(1));
        lit("rst_rd_bank", 32'(rd_bank), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        lit("ready_after_rst", 32'(fft_ready), 32'(1));

        // Full frame with fft_last on the final beat.
        send_frame(N, N - 1, 1);
        lit("f1_last_addr", 32'(wr_addr), 32'd255);
        lit("f1_bank", 32'(wr_bank), 32'(1));
        @(negedge clk);
        lit("f1_backpressure", 32'(fft_ready), 32'(0));
        lit("f1_no_swap", 32'(rd_bank), 32'(0));
        repeat (9) @(negedge clk);
        vs_pulse(1'b1);
        lit("ready_after_swap", 32'(fft_ready), 32'(1));

        // Short frame ending at beat 99.
        send_frame(100, 99, 2);
        lit("drop_wr_addr", 32'(wr_addr), 32'd99);
        lit("drop_bank", 32'(wr_bank), 32'(0));
        @(negedge clk);
        lit("drop_cnt_1", 32'(drop_cnt), 32'd1);
        send_frame(N, N - 1, 3);
        lit("no_swap_after_drop", 32'(rd_bank), 32'(1));
        vs_pulse(1'b0);

        // Full frame with no fft_last at all.
        send_frame(N, -1, 4);
        @(negedge clk);
        lit("nolast_full", 32'(fft_ready), 32'(0));
        lit("nolast_drop", 32'(drop_cnt), 32'd1);
        vs_pulse(1'b1);

        // vsync rising during fill is ignored.
        send_frame(50, -1, 5);
        vs_in = 1'b1;
        for (int i = 50; i < 53; i++) send_beat(32'(5 * 4096 + i), 1'b0);
        vs_in = 1'b0;
        lit("fill_vs_no_swap", 32'(rd_bank), 32'(1));
        for (int i = 53; i < N; i++) send_beat(32'(5 * 4096 + i), 1'b0);
        repeat (2) @(negedge clk);
        vs_pulse(1'b0);

        // Reset in the middle of a fill.
        send_frame(N / 2, -1, 6);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst_ready", 32'(fft_ready), 32'(0));
        lit("midrst_wr_en", 32'(wr_en), 32'(0));
        lit("midrst_wr_addr", 32'(wr_addr), 32'(0));
        lit("midrst_drop", 32'(drop_cnt), 32'(0));
        lit("midrst_rd", 32'(rd_bank), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        send_frame(N, N - 1, 7);
        lit("postrst_bank", 32'(wr_bank), 32'(1));
        vs_pulse(1'b1);

        // Single-beat frames are drops; counter saturates.
        for (int i = 0; i < 300; i++) send_beat(32'(i), 1'b1);
        @(negedge clk);
        lit("drop_saturate", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
